// File: rtl/morse_round_ctrl.sv
`default_nettype none
// ============================================================================
// morse_round_ctrl : times Morse key presses, checks them against a letter
//                    pattern and issues a win/lose verdict for one round.
// Revision: 1.0
// ============================================================================
module morse_round_ctrl #(
  parameter int MAX_SYMS = 5,
  parameter int DASH_MS  = 300,
  parameter int GAP_MS   = 700,
  parameter int CNT_W    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                key,
  input  logic                ms_tick,
  input  logic                TenSecTimeOut,
  input  logic [2:0]          exp_len,
  input  logic [MAX_SYMS-1:0] exp_pattern,
  output logic                timer_clear,
  output logic                timer_enable,
  output logic                busy,
  output logic [2:0]          sym_count,
  output logic [MAX_SYMS-1:0] sym_bits,
  output logic                done,
  output logic                win,
  output logic                lose
);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_ARM      = 3'd1;
  localparam logic [2:0] c_ST_WAIT_KEY = 3'd2;
  localparam logic [2:0] c_ST_PRESS    = 3'd3;
  localparam logic [2:0] c_ST_EVAL     = 3'd4;
  localparam logic [2:0] c_ST_RESULT   = 3'd5;

  localparam logic [CNT_W-1:0] c_dash_ms = CNT_W'(DASH_MS);
  localparam logic [CNT_W-1:0] c_gap_ms  = CNT_W'(GAP_MS);
  localparam logic [2:0]       c_max_len = 3'(MAX_SYMS);

  logic [2:0]          r_state;
  logic                r_key_q;
  logic [2:0]          r_exp_len;
  logic [MAX_SYMS-1:0] r_exp_pat;
  logic [2:0]          r_sym_count;
  logic [MAX_SYMS-1:0] r_sym_bits;
  logic [CNT_W-1:0]    r_press_ms;
  logic [CNT_W-1:0]    r_gap_ms;
  logic                r_win;
  logic                r_lose;

  logic                w_key_rise;
  logic                w_sym;
  logic                w_exp_bit;
  logic [MAX_SYMS-1:0] w_sym_bits_nxt;
  logic [2:0]          w_cnt_inc;
  logic [2:0]          w_len_clamped;
  logic [CNT_W-1:0]    w_gap_inc;

  assign w_key_rise    = key & ~r_key_q;
  assign w_sym         = (r_press_ms >= c_dash_ms);
  assign w_cnt_inc     = r_sym_count + 3'd1;
  assign w_gap_inc     = r_gap_ms + 1'b1;
  assign w_len_clamped = (exp_len > c_max_len) ? c_max_len : exp_len;

  // Symbol slot addressed by the current count, both for compare and write.
  always_comb begin
    w_exp_bit      = 1'b0;
    w_sym_bits_nxt = r_sym_bits;
    for (int i = 0; i < MAX_SYMS; i++) begin
      if (r_sym_count == 3'(i)) begin
        w_exp_bit         = r_exp_pat[i];
        w_sym_bits_nxt[i] = w_sym;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_ST_IDLE;
      r_key_q     <= 1'b0;
      r_exp_len   <= 3'd0;
      r_exp_pat   <= '0;
      r_sym_count <= 3'd0;
      r_sym_bits  <= '0;
      r_press_ms  <= '0;
      r_gap_ms    <= '0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
    end else begin
      r_key_q <= key;
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_exp_len   <= w_len_clamped;
            r_exp_pat   <= exp_pattern;
            r_sym_count <= 3'd0;
            r_sym_bits  <= '0;
            r_press_ms  <= '0;
            r_gap_ms    <= '0;
            r_win       <= 1'b0;
            r_lose      <= 1'b0;
            r_state     <= c_ST_ARM;
          end
        end
        c_ST_ARM: begin
          if (r_exp_len == 3'd0) begin
            r_lose  <= 1'b1;
            r_state <= c_ST_RESULT;
          end else begin
            r_state <= c_ST_WAIT_KEY;
          end
        end
        c_ST_WAIT_KEY: begin
          // Timeout outranks both a new press and gap expiry.
          if (TenSecTimeOut) begin
            r_lose  <= 1'b1;
            r_state <= c_ST_RESULT;
          end else if (w_key_rise) begin
            r_press_ms <= '0;
            r_state    <= c_ST_PRESS;
          end else if ((r_sym_count != 3'd0) && ms_tick) begin
            if (w_gap_inc >= c_gap_ms) begin
              r_lose  <= 1'b1;
              r_state <= c_ST_RESULT;
            end else begin
              r_gap_ms <= w_gap_inc;
            end
          end
        end
        c_ST_PRESS: begin
          if (TenSecTimeOut) begin
            r_lose  <= 1'b1;
            r_state <= c_ST_RESULT;
          end else begin
            if (ms_tick && (r_press_ms != '1)) begin
              r_press_ms <= r_press_ms + 1'b1;
            end
            if (!key) begin
              r_state <= c_ST_EVAL;
            end
          end
        end
        c_ST_EVAL: begin
          r_sym_bits  <= w_sym_bits_nxt;
          r_sym_count <= w_cnt_inc;
          if (w_sym != w_exp_bit) begin
            r_lose  <= 1'b1;
            r_state <= c_ST_RESULT;
          end else if (w_cnt_inc == r_exp_len) begin
            r_win   <= 1'b1;
            r_state <= c_ST_RESULT;
          end else begin
            r_gap_ms <= '0;
            r_state  <= c_ST_WAIT_KEY;
          end
        end
        c_ST_RESULT: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign timer_clear  = (r_state == c_ST_ARM);
  assign timer_enable = (r_state == c_ST_WAIT_KEY) || (r_state == c_ST_PRESS) ||
                        (r_state == c_ST_EVAL);
  assign busy         = (r_state != c_ST_IDLE);
  assign done         = (r_state == c_ST_RESULT);
  assign sym_count    = r_sym_count;
  assign sym_bits     = r_sym_bits;
  assign win          = r_win;
  assign lose         = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_morse_round_ctrl.sv
`default_nettype none
// ============================================================================
// tb_morse_round_ctrl : directed bench for morse_round_ctrl.
// Revision: 1.0
// ============================================================================
module tb_morse_round_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       key;
  logic       ms_tick;
  logic       TenSecTimeOut;
  logic [2:0] exp_len;
  logic [4:0] exp_pattern;
  logic       timer_clear;
  logic       timer_enable;
  logic       busy;
  logic [2:0] sym_count;
  logic [4:0] sym_bits;
  logic       done;
  logic       win;
  logic       lose;

  int n_checks = 0;
  int n_errors = 0;

  morse_round_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key          (key),
    .ms_tick      (ms_tick),
    .TenSecTimeOut(TenSecTimeOut),
    .exp_len      (exp_len),
    .exp_pattern  (exp_pattern),
    .timer_clear  (timer_clear),
    .timer_enable (timer_enable),
    .busy         (busy),
    .sym_count    (sym_count),
    .sym_bits     (sym_bits),
    .done         (done),
    .win          (win),
    .lose         (lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic run_ms(input int n);
    for (int i = 0; i < n; i++) begin
      ms_tick = 1'b1;
      step();
      ms_tick = 1'b0;
      step();
    end
  endtask

  // Leaves the DUT in WAIT_KEY (or RESULT when exp_len is 0).
  task automatic do_start(input logic [2:0] len, input logic [4:0] pat);
    exp_len     = len;
    exp_pattern = pat;
    start       = 1'b1;
    step();
    start = 1'b0;
    chk("arm_clear", timer_clear, 1);
    chk("arm_verdict_clr", {win, lose}, 0);
    step();
  endtask

  // Press for n ms; returns with the DUT in EVAL.
  task automatic press(input int n);
    key = 1'b1;
    step();
    run_ms(n);
    key = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; key = 1'b0; ms_tick = 1'b0; TenSecTimeOut = 1'b0;
    exp_len = 3'd0; exp_pattern = 5'd0;
    step(); step();
    chk("rst_outs", {timer_clear, timer_enable, busy, done, win, lose}, 0);
    chk("rst_syms", {sym_count, sym_bits}, 0);
    rst = 1'b1;
    step();

    // single dot, 120 ms
    do_start(3'd1, 5'b00000);
    chk("t1_enable", timer_enable, 1);
    press(120);
    chk("t1_eval_nodone", done, 0);
    step();
    chk("t1_done", {done, win, lose}, 3'b110);
    chk("t1_syms", {sym_count, sym_bits}, {3'd1, 5'b00000});
    chk("t1_enable_off", timer_enable, 0);
    step();
    chk("t1_idle", {busy, done, win}, 3'b001);

    // dot then dash at exact DASH_MS
    do_start(3'd2, 5'b00010);
    press(100);
    step();
    chk("t2_mid", {busy, sym_count, sym_bits}, {1'b1, 3'd1, 5'b00000});
    run_ms(200);
    press(300);
    step();
    chk("t2_done", {done, win, lose}, 3'b110);
    chk("t2_syms", {sym_count, sym_bits}, {3'd2, 5'b00010});
    step();

    // dash where dot expected
    do_start(3'd3, 5'b00000);
    press(400);
    step();
    chk("t3_done", {done, win, lose}, 3'b101);
    chk("t3_syms", {sym_count, sym_bits}, {3'd1, 5'b00001});
    step();

    // gap expiry
    do_start(3'd3, 5'b00000);
    press(50);
    step();
    run_ms(699);
    chk("t4_before", {busy, done, lose}, 3'b100);
    ms_tick = 1'b1;
    step();
    ms_tick = 1'b0;
    chk("t4_done", {done, win, lose}, 3'b101);
    chk("t4_cnt", sym_count, 1);
    step();

    // timeout mid-press
    do_start(3'd5, 5'b00000);
    key = 1'b1;
    step();
    run_ms(50);
    TenSecTimeOut = 1'b1;
    step();
    TenSecTimeOut = 1'b0;
    chk("t5a_done", {done, win, lose, timer_enable}, 4'b1010);
    chk("t5a_syms", {sym_count, sym_bits}, 0);
    key = 1'b0;
    step();
    // timeout coincident with release
    do_start(3'd5, 5'b00000);
    key = 1'b1;
    step();
    run_ms(20);
    key = 1'b0;
    TenSecTimeOut = 1'b1;
    step();
    TenSecTimeOut = 1'b0;
    chk("t5b_done", {done, win, lose, timer_enable}, 4'b1010);
    chk("t5b_syms", {sym_count, sym_bits}, 0);
    step();

    // exp_len of zero loses straight from ARM
    do_start(3'd0, 5'b00000);
    chk("t_len0", {done, win, lose}, 3'b101);
    step();

    // exp_len above MAX_SYMS is clamped to 5
    do_start(3'd6, 5'b00000);
    for (int i = 0; i < 5; i++) begin
      press(10);
      step();
    end
    chk("t_clamp_done", {done, win, lose}, 3'b110);
    chk("t_clamp_syms", {sym_count, sym_bits}, {3'd5, 5'b00000});
    step();

    // key held at start is not a press; starts while busy ignored
    key = 1'b1;
    step();
    do_start(3'd1, 5'b00000);
    run_ms(400);
    key = 1'b0;
    step(); step();
    chk("t6_held", {busy, done, sym_count}, {1'b1, 1'b0, 3'd0});
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_busy_start", timer_clear, 0);
    press(60);
    step();
    start = 1'b1;
    chk("t6_done", {done, win, lose, sym_count}, {3'b110, 3'd1});
    step();
    start = 1'b0;
    chk("t6_start_in_result", {busy, timer_clear}, 0);

    // async reset mid-press
    do_start(3'd2, 5'b00000);
    key = 1'b1;
    step();
    run_ms(10);
    #2 rst = 1'b0;
    #1;
    chk("t7_async", {timer_clear, timer_enable, busy, done, win, lose, sym_count, sym_bits}, 0);
    key = 1'b0;
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t7_after", {busy, done, win, lose}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
